// File: rtl/vcu108_uart_rx_if.sv
// Receive-side handshake and status bundle for vcu108_uart_rx.
// master = receiver, slave = byte consumer.
interface vcu108_uart_rx_if;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       framing_error;
    logic       overrun;
    logic       parity_error;

    modport master (
        output rx_valid,
        output rx_data,
        output framing_error,
        output overrun,
        output parity_error,
        input  rx_ready
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  framing_error,
        input  overrun,
        input  parity_error,
        output rx_ready
    );
endinterface

// File: rtl/vcu108_uart_rx.sv
// 16x-oversampling UART receiver with a small receive FIFO and CTS flow control.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits (8E1 instead of 8N1).
module vcu108_uart_rx #(
    parameter int CLK_DIV    = 27,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             uart_rxd,
    output logic             uart_cts,
    vcu108_uart_rx_if.master rx_if
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CW-1:0]    CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]    CNT_ALERT = CW'(FIFO_DEPTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

    logic [1:0]       r_sync;
    logic             r_rxd_prev;
    logic [1:0]       r_settle;
    logic [DIV_W-1:0] r_div;
    state_t           r_state;
    logic [3:0]       r_tick_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_push;
    logic             r_framing;
`ifdef UART_RX_PARITY_EN
    logic             r_parity;
    logic             r_par_bad;
`endif
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overrun;
    logic             r_cts;

    logic             w_rxd;
    logic             w_start_edge;
    logic             w_tick;
    logic             w_valid;
    logic             w_pop;
    logic             w_full;
    logic             w_write;
    logic [CW-1:0]    w_count_next;

    // Edges are ignored until the synchroniser and edge register hold real line samples after reset,
    // so a line already low at reset release is not mistaken for a start bit.
    assign w_rxd        = r_sync[1];
    assign w_start_edge = (r_settle == 2'd3) && r_rxd_prev && !w_rxd;
    assign w_tick       = (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync     <= 2'b11;
            r_rxd_prev <= 1'b1;
            r_settle   <= 2'd0;
        end else begin
            r_sync     <= {r_sync[0], uart_rxd};
            r_rxd_prev <= w_rxd;
            if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state == IDLE && w_start_edge)) r_div <= '0;
        else if (w_tick)                                r_div <= '0;
        else                                            r_div <= r_div + DIV_W'(1);
    end

    // Sample points: tick 8 re-checks the start bit, then every 16th tick is a bit centre.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tick_cnt <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_push     <= 1'b0;
            r_framing  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity   <= 1'b0;
            r_par_bad  <= 1'b0;
`endif
        end else begin
            r_push    <= 1'b0;
            r_framing <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity  <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        r_state    <= START;
                        r_tick_cnt <= 4'd0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == 4'd7) begin
                            r_tick_cnt <= 4'd0;
                            r_bit_idx  <= 3'd0;
                            r_state    <= w_rxd ? IDLE : DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (r_tick_cnt == 4'd15) begin
                            r_shift   <= {w_rxd, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                            if (r_bit_idx == 3'd7) r_state <= PARITY;
`else
                            if (r_bit_idx == 3'd7) r_state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (r_tick_cnt == 4'd15) begin
                            r_par_bad <= w_rxd ^ (^r_shift);
                            r_state   <= STOP;
                        end
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (r_tick_cnt == 4'd15) begin
                            if (!w_rxd) begin
                                r_framing <= 1'b1;
                                r_state   <= WAIT_HIGH;
                            end
`ifdef UART_RX_PARITY_EN
                            else if (r_par_bad) begin
                                r_parity <= 1'b1;
                                r_state  <= IDLE;
                            end
`endif
                            else begin
                                r_push  <= 1'b1;
                                r_state <= IDLE;
                            end
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (w_rxd) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A pop frees the slot before the push lands, so a full FIFO being drained never overruns.
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && rx_if.rx_ready;
    assign w_full  = (r_count == CNT_FULL);
    assign w_write = r_push && (!w_full || w_pop);

    always_comb begin
        w_count_next = r_count;
        if (w_write && !w_pop)      w_count_next = r_count + CW'(1);
        else if (!w_write && w_pop) w_count_next = r_count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_cts     <= 1'b0;
        end else begin
            r_overrun <= r_push && w_full && !w_pop;
            if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count   <= w_count_next;
            r_cts     <= (w_count_next >= CNT_ALERT);
        end
    end

    assign uart_cts            = r_cts;
    assign rx_if.rx_valid      = w_valid;
    assign rx_if.rx_data       = w_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign rx_if.framing_error = r_framing;
    assign rx_if.overrun       = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_error  = r_parity;
`else
    assign rx_if.parity_error  = 1'b0;
`endif
endmodule

// File: tb/tb_vcu108_uart_rx.sv
// Self-checking bench for vcu108_uart_rx: serial frames are driven bit by bit and the
// delivered bytes and error pulses are compared with a queue-based model of the receiver.
module tb_vcu108_uart_rx;
    localparam int CLK_DIV    = 27;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT_CYC    = 16 * CLK_DIV;

    logic clk = 1'b0;
    logic reset;
    logic uart_rxd;
    logic uart_cts;

    vcu108_uart_rx_if rx_if ();

    vcu108_uart_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rxd (uart_rxd),
        .uart_cts (uart_cts),
        .rx_if    (rx_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int fe_cnt = 0;
    int ovr_cnt = 0;
    int pe_cnt = 0;
    int valid_cyc = 0;
`ifdef UART_RX_PARITY_EN
    bit par_flip = 1'b0;
`endif

    // Consumer-side monitor: records accepted bytes and counts pulses away from the clock edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_if.rx_valid && rx_if.rx_ready) got_q.push_back(rx_if.rx_data);
            if (rx_if.framing_error) fe_cnt++;
            if (rx_if.overrun)       ovr_cnt++;
            if (rx_if.parity_error)  pe_cnt++;
            if (rx_if.rx_valid)      valid_cyc++;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        uart_rxd = b;
        wait_cycles(BIT_CYC);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        uart_rxd = 1'b1;
        rx_if.rx_ready = 1'b1;
        wait_cycles(5);
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", rx_if.rx_valid); end
        checks++; if (rx_if.rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h want 00", rx_if.rx_data); end
        checks++; if (uart_cts !== 1'b0) begin errors++; $display("[TB] FAIL reset_cts: got %b want 0", uart_cts); end
        checks++; if ({rx_if.framing_error, rx_if.overrun, rx_if.parity_error} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_pulses: got %b want 000", {rx_if.framing_error, rx_if.overrun, rx_if.parity_error});
        end
        reset = 1'b0;
        wait_cycles(BIT_CYC);
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid: got %b want 0", rx_if.rx_valid); end
    endtask

    task automatic test_single_frame();
        int v0, e0;
        got_q.delete(); exp_q.delete();
        v0 = valid_cyc; e0 = fe_cnt + ovr_cnt + pe_cnt;
        rx_if.rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        exp_q.push_back(8'hA5);
        wait_cycles(BIT_CYC / 2);
        checks++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("[TB] FAIL single_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL single_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (valid_cyc - v0 != 1) begin errors++; $display("[TB] FAIL single_valid_cycles: got %0d want 1", valid_cyc - v0); end
        checks++; if (fe_cnt + ovr_cnt + pe_cnt - e0 != 0) begin errors++; $display("[TB] FAIL single_errors: got %0d want 0", fe_cnt + ovr_cnt + pe_cnt - e0); end
    endtask

    task automatic test_glitch();
        int v0, e0;
        v0 = valid_cyc; e0 = fe_cnt + ovr_cnt + pe_cnt;
        uart_rxd = 1'b0;
        wait_cycles(4 * CLK_DIV);
        uart_rxd = 1'b1;
        wait_cycles(2 * BIT_CYC);
        checks++; if (valid_cyc - v0 != 0) begin errors++; $display("[TB] FAIL glitch_valid_cycles: got %0d want 0", valid_cyc - v0); end
        checks++; if (fe_cnt + ovr_cnt + pe_cnt - e0 != 0) begin errors++; $display("[TB] FAIL glitch_errors: got %0d want 0", fe_cnt + ovr_cnt + pe_cnt - e0); end
    endtask

    // With the consumer stalled, the model keeps the first FIFO_DEPTH bytes and counts the rest as overruns.
    task automatic test_overrun();
        int o0, exp_ovr;
        logic [7:0] held [$];
        got_q.delete();
        o0 = ovr_cnt; exp_ovr = 0;
        rx_if.rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1);
            if (held.size() < FIFO_DEPTH) held.push_back(8'(k));
            else exp_ovr++;
            wait_cycles(4);
            checks++; if (uart_cts !== (held.size() >= FIFO_DEPTH - 1)) begin
                errors++; $display("[TB] FAIL ovr_cts_after_%0d: got %b want %b", k, uart_cts, held.size() >= FIFO_DEPTH - 1);
            end
            checks++; if (ovr_cnt - o0 != exp_ovr) begin errors++; $display("[TB] FAIL ovr_pulses_after_%0d: got %0d want %0d", k, ovr_cnt - o0, exp_ovr); end
        end
        checks++; if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== held[0]) begin
            errors++; $display("[TB] FAIL ovr_head: got valid=%b data=%h want valid=1 data=%h", rx_if.rx_valid, rx_if.rx_data, held[0]);
        end
        rx_if.rx_ready = 1'b1;
        wait_cycles(10);
        checks++; if (got_q.size() != held.size()) begin
            errors++; $display("[TB] FAIL drain_count: got %0d bytes want %0d", got_q.size(), held.size());
        end else foreach (held[i]) begin
            checks++; if (got_q[i] !== held[i]) begin errors++; $display("[TB] FAIL drain_data[%0d]: got %h want %h", i, got_q[i], held[i]); end
        end
        checks++; if (uart_cts !== 1'b0) begin errors++; $display("[TB] FAIL drain_cts: got %b want 0", uart_cts); end
    endtask

    task automatic test_framing();
        int f0, o0, p0;
        got_q.delete(); exp_q.delete();
        f0 = fe_cnt; o0 = ovr_cnt; p0 = pe_cnt;
        rx_if.rx_ready = 1'b1;
        send_frame(8'h3C, 1'b0);
        uart_rxd = 1'b0;
        wait_cycles(40 * BIT_CYC);
        uart_rxd = 1'b1;
        wait_cycles(2 * BIT_CYC);
        send_frame(8'h55, 1'b1);
        exp_q.push_back(8'h55);
        wait_cycles(BIT_CYC / 2);
        checks++; if (fe_cnt - f0 != 1) begin errors++; $display("[TB] FAIL break_framing_pulses: got %0d want 1", fe_cnt - f0); end
        checks++; if (ovr_cnt - o0 + pe_cnt - p0 != 0) begin errors++; $display("[TB] FAIL break_other_pulses: got %0d want 0", ovr_cnt - o0 + pe_cnt - p0); end
        checks++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("[TB] FAIL break_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL break_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        int e0;
        got_q.delete(); exp_q.delete();
        e0 = fe_cnt + ovr_cnt + pe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        uart_rxd = 1'b1;
        wait_cycles(BIT_CYC / 2);
        reset = 1'b1;
        wait_cycles(4);
        reset = 1'b0;
        wait_cycles(BIT_CYC / 2);
        for (int i = 4; i < 8; i++) send_bit(1'b1);
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0);
`endif
        send_bit(1'b1);
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL abandon_valid: got %b want 0", rx_if.rx_valid); end
        wait_cycles(BIT_CYC);
        send_frame(8'h12, 1'b1);
        exp_q.push_back(8'h12);
        wait_cycles(BIT_CYC / 2);
        checks++; if (fe_cnt + ovr_cnt + pe_cnt - e0 != 0) begin errors++; $display("[TB] FAIL abandon_errors: got %0d want 0", fe_cnt + ovr_cnt + pe_cnt - e0); end
        checks++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("[TB] FAIL abandon_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL abandon_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    // Random bytes with random consumer stalls and inter-frame gaps (gap 0 = back-to-back frames).
    task automatic test_back_to_back();
        int e0;
        logic [7:0] d;
        got_q.delete(); exp_q.delete();
        e0 = fe_cnt + ovr_cnt + pe_cnt;
        for (int k = 0; k < 2; k++) begin
            d = 8'($urandom);
            rx_if.rx_ready = 1'($urandom_range(0, 1));
            send_frame(d, 1'b1);
            exp_q.push_back(d);
            if ($urandom_range(0, 1) == 1) send_bit(1'b1);
        end
        rx_if.rx_ready = 1'b1;
        wait_cycles(10);
        checks++; if (fe_cnt + ovr_cnt + pe_cnt - e0 != 0) begin errors++; $display("[TB] FAIL b2b_errors: got %0d want 0", fe_cnt + ovr_cnt + pe_cnt - e0); end
        checks++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("[TB] FAIL b2b_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL b2b_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int p0, f0;
        got_q.delete(); exp_q.delete();
        p0 = pe_cnt; f0 = fe_cnt;
        rx_if.rx_ready = 1'b1;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        wait_cycles(BIT_CYC / 2);
        checks++; if (pe_cnt - p0 != 1) begin errors++; $display("[TB] FAIL parity_bad_pulses: got %0d want 1", pe_cnt - p0); end
        checks++; if (got_q.size() != 0) begin errors++; $display("[TB] FAIL parity_bad_data: got %0d bytes want 0", got_q.size()); end
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        exp_q.push_back(8'h07);
        wait_cycles(BIT_CYC / 2);
        checks++; if (pe_cnt - p0 != 1 || fe_cnt - f0 != 0) begin
            errors++; $display("[TB] FAIL parity_good_pulses: got pe=%0d fe=%0d want pe=1 fe=0", pe_cnt - p0, fe_cnt - f0);
        end
        checks++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("[TB] FAIL parity_good_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL parity_good_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_overrun();
        test_framing();
        test_reset_midframe();
        test_back_to_back();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vcu108_uart_rx.md
VCU108_UART_RX -- requirements
Module: vcu108_uart_rx

Interface
REQ-001 Parameter CLK_DIV, default 27, meaning clk cycles per 1/16 bit period (50 MHz clock, 115200 baud).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning receive FIFO entries; the value SHALL be a power of two, minimum 2.
REQ-003 Ports, clock and reset first: clk  in  1  single clock for all logic.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 uart_rxd  in  1  asynchronous serial line; idle high.
REQ-006 uart_cts  out  1  active-low clear-to-send: 0 = host may send.
REQ-007 rx_valid  out  1  FIFO head byte available.
REQ-008 rx_ready  in  1  consumer accepts the head byte.
REQ-009 rx_data  out  8  FIFO head byte.
REQ-010 framing_error  out  1  one-cycle pulse.
REQ-011 overrun  out  1  one-cycle pulse.
REQ-012 parity_error  out  1  one-cycle pulse; tied 0 when the parity feature is compiled out.

Function
REQ-013 uart_rxd SHALL pass through a 2-flop synchroniser, and all decisions SHALL use the synchronised value.
REQ-014 A tick SHALL assert for one cycle every CLK_DIV cycles from a free-running divider; the divider SHALL restart when a start edge is detected.
REQ-015 The state machine SHALL have the states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-016 IDLE SHALL move to START on a synchronised high-to-low edge.
REQ-017 START SHALL re-check the line at tick 8; if the line is high it SHALL return to IDLE (false start, nothing reported); otherwise it SHALL move to DATA.
REQ-018 DATA SHALL sample 8 bits, LSB first, each at 16 ticks after the previous sample, then move to PARITY if the feature is compiled in, else to STOP.
REQ-019 STOP SHALL sample at 16 ticks; a high sample is a valid frame and returns to IDLE.
REQ-020 A low stop sample SHALL pulse framing_error, discard the byte and move to WAIT_HIGH.
REQ-021 WAIT_HIGH SHALL return to IDLE only after the synchronised line is high; a break therefore yields exactly one framing_error.
REQ-022 A valid byte SHALL be written to the FIFO the cycle after the stop sample, and rx_valid SHALL assert the following cycle if the FIFO was empty.
REQ-023 If the FIFO is full at write, the byte SHALL be dropped, overrun SHALL pulse once, and the FIFO contents SHALL be unchanged.
REQ-024 A FIFO pop SHALL occur on rx_valid && rx_ready, and rx_data SHALL be stable while rx_valid=1 and rx_ready=0.
REQ-025 A simultaneous push and pop SHALL leave the count unchanged, including when full: pop first, so no overrun.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and the count width SHALL be log2(FIFO_DEPTH)+1.
REQ-027 uart_cts SHALL be 1 when count >= FIFO_DEPTH-1, else 0, and SHALL be registered.
REQ-028 At most one error pulse SHALL assert per frame.

Reset
REQ-029 While reset=1, the state SHALL be IDLE, the FIFO SHALL be emptied, the divider SHALL be cleared, and the synchroniser SHALL be set to 1.
REQ-030 Output reset values SHALL be: rx_valid=0, rx_data=0, uart_cts=0, and all error pulses 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame without an error pulse; a frame whose start edge preceded reset release SHALL NOT be received.

Configuration
REQ-032 The macro UART_RX_PARITY_EN SHALL control the parity feature.
REQ-033 When UART_RX_PARITY_EN is defined, the PARITY state SHALL sample one even-parity bit after the data bits.
REQ-034 With the macro defined, a mismatch SHALL pulse parity_error at the stop sample and discard the byte; if the stop bit is also low, only framing_error SHALL pulse.
REQ-035 When UART_RX_PARITY_EN is undefined, the PARITY state SHALL be absent, the frame SHALL be 8N1, and parity_error SHALL be constant 0.

Verification
REQ-036 Scenario: frame 0xA5 at CLK_DIV=27 with rx_ready=1 -> rx_valid for 1 cycle with rx_data=0xA5 and no error pulses.
REQ-037 Scenario: a low glitch of 4*CLK_DIV cycles on an idle line -> no FIFO write and the FSM back in IDLE.
REQ-038 Scenario: rx_ready=0 and 5 frames 0x01..0x05 -> uart_cts=1 after the 3rd byte, overrun pulses once on the 5th, and draining yields 0x01..0x04.
REQ-039 Scenario: frame 0x3C with the stop bit low, then the line held low for 40 bit times -> exactly one framing_error and no data; a following 0x55 is received correctly.
REQ-040 Scenario: reset pulsed at the 4th data bit of 0xFF, then a clean 0x12 -> only 0x12 delivered.
REQ-041 Scenario (UART_RX_PARITY_EN defined): frame 0x07 with parity bit 0 -> parity_error pulse and no data; with parity bit 1 -> 0x07 delivered.
